// File: rtl/fetch_queue_pkg.sv
// Shared CPU fetch definitions: default widths, the fetch-entry record handed
// to decode, and the occupancy-counter width helper.
package fetch_queue_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 32;
  localparam int DEPTH_DEF   = 4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

  // A counter able to hold 0..depth inclusive needs one bit beyond the pointer.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with clear, occupancy count and
// zeroed read data when empty. Storage is deliberately not reset.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter int  WIDTH = ADDR_W_DEF + INSTR_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_fire;
  logic             rd_fire;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign wr_fire = wr_en && !full && !clear;
  assign rd_fire = rd_en && !empty && !clear;
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: credit-based PC acceptance, one synchronous imem
// read per accepted PC, buffering of {pc, instr} for decode, branch flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int  ADDR_W  = ADDR_W_DEF,
  parameter int  INSTR_W = INSTR_W_DEF,
  parameter int  DEPTH   = DEPTH_DEF,
  localparam int CNT_W   = count_width(DEPTH)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic               i_pc_valid,
  output logic               o_pc_ready,
  output logic               o_imem_en,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_data,
  input  logic               i_flush,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_instr_pc,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  output logic [CNT_W-1:0]   o_count
);

  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic                inflight_q, inflight_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CNT_W:0]      credits_used;
  logic                credit_ok;
  logic                pc_ready;
  logic                accept;
  logic                capture;
  logic                dequeue;
  logic [ENTRY_W-1:0]  fifo_rd_data;
  logic                fifo_empty;
  logic                fifo_full;
  logic [CNT_W-1:0]    fifo_count;

  // A read in flight already owns a slot, so it is counted as occupied.
  assign credits_used = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q);
  assign credit_ok    = credits_used < (CNT_W+1)'(DEPTH);
  assign pc_ready     = RST_N && !i_flush && credit_ok;
  assign accept       = i_pc_valid && pc_ready;

  assign o_pc_ready  = pc_ready;
  assign o_imem_en   = accept;
  assign o_imem_addr = RST_N ? i_pc : '0;

  assign capture = inflight_q && !i_flush && !fifo_full;
  assign dequeue = !fifo_empty && i_instr_ready && !i_flush;

  always_comb begin
    inflight_d = accept;
    pc_d       = pc_q;
    if (accept) pc_d = i_pc;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      inflight_q <= 1'b0;
      pc_q       <= '0;
    end else begin
      inflight_q <= inflight_d;
      pc_q       <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clear   (i_flush),
    .wr_en   (capture),
    .wr_data ({pc_q, i_imem_data}),
    .rd_en   (dequeue),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign {o_instr_pc, o_instr} = fifo_rd_data;
  assign o_instr_valid         = !fifo_empty;
  assign o_count               = fifo_count;

endmodule
